// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared types for the register-file W2 write-back path
package riscv_wb_pkg;

   localparam int WB_ADDR_WIDTH = 5;
   localparam int WB_DATA_WIDTH = 32;
   localparam int NUM_WORDS     = 2**WB_ADDR_WIDTH;

   typedef struct packed {
      logic [WB_ADDR_WIDTH-1:0] waddr;
      logic [WB_DATA_WIDTH-1:0] wdata;
   } wb_entry_t;

endpackage

// File: rtl/riscv_wb_fifo.sv
// rtl/riscv_wb_fifo.sv - synchronous load-return queue of write-back entries
module riscv_wb_fifo
   import riscv_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  wb_entry_t                  din,
   output wb_entry_t                  dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t     mem [DEPTH];
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;

   // The extra wrap bit tells full (lap ahead) apart from empty (same lap).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count = CW'(wr_ptr - rd_ptr);
   assign dout  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/riscv_wb_port_b_arbiter.sv
// rtl/riscv_wb_port_b_arbiter.sv - W2 write-back arbiter, load queue and pending scoreboard
module riscv_wb_port_b_arbiter
   import riscv_wb_pkg::*;
#(
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       md_valid_i,
   input  logic [ADDR_WIDTH-1:0]      md_waddr_i,
   input  logic [DATA_WIDTH-1:0]      md_wdata_i,
   input  logic                       lsu_valid_i,
   input  logic [ADDR_WIDTH-1:0]      lsu_waddr_i,
   input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
   output logic                       lsu_ready_o,
   input  logic                       issue_valid_i,
   input  logic [ADDR_WIDTH-1:0]      issue_waddr_i,
   input  logic [ADDR_WIDTH-1:0]      chk_raddr_a_i,
   input  logic [ADDR_WIDTH-1:0]      chk_raddr_b_i,
   input  logic [ADDR_WIDTH-1:0]      chk_raddr_c_i,
   input  logic [ADDR_WIDTH-1:0]      chk_waddr_i,
   output logic                       stall_o,
   output logic                       we_b_o,
   output logic [ADDR_WIDTH-1:0]      waddr_b_o,
   output logic [DATA_WIDTH-1:0]      wdata_b_o,
   output logic [$clog2(DEPTH+1)-1:0] q_count_o
);

   localparam int NREGS = 2**ADDR_WIDTH;

   wb_entry_t         push_entry;
   wb_entry_t         head;
   logic              q_full;
   logic              q_empty;
   logic              q_push;
   logic              q_pop;
   logic [NREGS-1:0]  pending;
   logic [NREGS-1:0]  pending_nxt;

   assign push_entry  = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
   assign lsu_ready_o = !q_full;
   assign q_push      = lsu_valid_i && !q_full;
   // Mult/div cannot be back-pressured, so the queue only drains on idle cycles.
   assign q_pop       = !md_valid_i && !q_empty;

   riscv_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .pop   (q_pop),
      .din   (push_entry),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         we_b_o    <= 1'b0;
         waddr_b_o <= '0;
         wdata_b_o <= '0;
      end else if (md_valid_i) begin
         we_b_o    <= (md_waddr_i != '0);
         waddr_b_o <= md_waddr_i;
         wdata_b_o <= md_wdata_i;
      end else if (!q_empty) begin
         we_b_o    <= (head.waddr != '0);
         waddr_b_o <= head.waddr;
         wdata_b_o <= head.wdata;
      end else begin
         we_b_o    <= 1'b0;
      end
   end

   // A set applied after the clear lets a new issue win over a retiring write.
   always_comb begin
      pending_nxt = pending;
      if (we_b_o) begin
         pending_nxt[waddr_b_o] = 1'b0;
      end
      if (issue_valid_i && (issue_waddr_i != '0)) begin
         pending_nxt[issue_waddr_i] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   assign stall_o = pending[chk_raddr_a_i] | pending[chk_raddr_b_i] |
                    pending[chk_raddr_c_i] | pending[chk_waddr_i];

endmodule

// File: tb/tb_riscv_wb_port_b_arbiter.sv
// tb/tb_riscv_wb_port_b_arbiter.sv - self-checking bench for the W2 write-back arbiter
module tb_riscv_wb_port_b_arbiter;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        md_valid_i;
   logic [4:0]  md_waddr_i;
   logic [31:0] md_wdata_i;
   logic        lsu_valid_i;
   logic [4:0]  lsu_waddr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_ready_o;
   logic        issue_valid_i;
   logic [4:0]  issue_waddr_i;
   logic [4:0]  chk_raddr_a_i;
   logic [4:0]  chk_raddr_b_i;
   logic [4:0]  chk_raddr_c_i;
   logic [4:0]  chk_waddr_i;
   logic        stall_o;
   logic        we_b_o;
   logic [4:0]  waddr_b_o;
   logic [31:0] wdata_b_o;
   logic [2:0]  q_count_o;

   riscv_wb_port_b_arbiter #(
      .ADDR_WIDTH (5),
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .md_valid_i    (md_valid_i),
      .md_waddr_i    (md_waddr_i),
      .md_wdata_i    (md_wdata_i),
      .lsu_valid_i   (lsu_valid_i),
      .lsu_waddr_i   (lsu_waddr_i),
      .lsu_wdata_i   (lsu_wdata_i),
      .lsu_ready_o   (lsu_ready_o),
      .issue_valid_i (issue_valid_i),
      .issue_waddr_i (issue_waddr_i),
      .chk_raddr_a_i (chk_raddr_a_i),
      .chk_raddr_b_i (chk_raddr_b_i),
      .chk_raddr_c_i (chk_raddr_c_i),
      .chk_waddr_i   (chk_waddr_i),
      .stall_o       (stall_o),
      .we_b_o        (we_b_o),
      .waddr_b_o     (waddr_b_o),
      .wdata_b_o     (wdata_b_o),
      .q_count_o     (q_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        exp_q[$];
   bit          exp_pend[32];
   logic        exp_we;
   logic [4:0]  exp_waddr;
   logic [31:0] exp_wdata;
   int          n_cmp;
   int          n_err;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_stall;
      exp_stall = exp_pend[chk_raddr_a_i] | exp_pend[chk_raddr_b_i] |
                  exp_pend[chk_raddr_c_i] | exp_pend[chk_waddr_i];
      cmp({tag, ".we"},    32'(we_b_o),      32'(exp_we));
      cmp({tag, ".waddr"}, 32'(waddr_b_o),   32'(exp_waddr));
      cmp({tag, ".wdata"}, wdata_b_o,        exp_wdata);
      cmp({tag, ".count"}, 32'(q_count_o),   32'(exp_q.size()));
      cmp({tag, ".ready"}, 32'(lsu_ready_o), 32'(exp_q.size() < DEPTH));
      cmp({tag, ".stall"}, 32'(stall_o),     32'(exp_stall));
   endtask

   // Reference: one clock of the write-back rules applied to the queue/scoreboard model.
   task automatic tick(input string tag);
      bit   push_e;
      ent_t e;
      push_e = lsu_valid_i && (exp_q.size() < DEPTH);
      if (exp_we) exp_pend[exp_waddr] = 1'b0;
      if (issue_valid_i && issue_waddr_i != 0) exp_pend[issue_waddr_i] = 1'b1;
      if (md_valid_i) begin
         exp_we = (md_waddr_i != 0); exp_waddr = md_waddr_i; exp_wdata = md_wdata_i;
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         exp_we = (e.a != 0); exp_waddr = e.a; exp_wdata = e.d;
      end else begin
         exp_we = 1'b0;
      end
      if (push_e) begin
         e.a = lsu_waddr_i; e.d = lsu_wdata_i;
         exp_q.push_back(e);
      end
      if (rst) begin
         exp_q.delete();
         foreach (exp_pend[i]) exp_pend[i] = 1'b0;
         exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      md_valid_i = 0; md_waddr_i = 0; md_wdata_i = 0;
      lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
      issue_valid_i = 0; issue_waddr_i = 0;
      chk_raddr_a_i = 0; chk_raddr_b_i = 0; chk_raddr_c_i = 0; chk_waddr_i = 0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      exp_we = 0; exp_waddr = 0; exp_wdata = 0;
      foreach (exp_pend[i]) exp_pend[i] = 1'b0;
      idle_inputs();

      // Reset values
      rst = 1;
      tick("reset");
      tick("reset2");
      cmp("reset.we", 32'(we_b_o), 0);
      cmp("reset.count", 32'(q_count_o), 0);
      cmp("reset.ready", 32'(lsu_ready_o), 1);
      cmp("reset.stall", 32'(stall_o), 0);
      rst = 0;

      // Issue x5 then reset clears the pending bit
      issue_valid_i = 1; issue_waddr_i = 5; chk_raddr_a_i = 5;
      tick("issue5");
      cmp("issue5.stall", 32'(stall_o), 1);
      issue_valid_i = 0; rst = 1;
      tick("rst_clears");
      cmp("rst_clears.stall", 32'(stall_o), 0);
      rst = 0;

      // Single load to x3 with the port idle
      issue_valid_i = 1; issue_waddr_i = 3; chk_raddr_a_i = 3;
      tick("issue3");
      issue_valid_i = 0;
      lsu_valid_i = 1; lsu_waddr_i = 3; lsu_wdata_i = 32'hDEADBEEF;
      tick("load3_push");
      lsu_valid_i = 0;
      tick("load3_wb");
      cmp("load3.we", 32'(we_b_o), 1);
      cmp("load3.waddr", 32'(waddr_b_o), 3);
      cmp("load3.wdata", wdata_b_o, 32'hDEADBEEF);
      cmp("load3.stall_before", 32'(stall_o), 1);
      tick("load3_after");
      cmp("load3.stall_after", 32'(stall_o), 0);
      chk_raddr_a_i = 0;

      // Four loads while mult/div holds the port for six cycles
      for (int i = 0; i < 10; i++) begin
         md_valid_i  = (i < 6); md_waddr_i = 5'(16 + i); md_wdata_i = $urandom;
         lsu_valid_i = (i < 4); lsu_waddr_i = 5'(i + 1); lsu_wdata_i = $urandom;
         tick("md_burst");
         if (i == 3) begin
            cmp("burst.full_count", 32'(q_count_o), 4);
            cmp("burst.full_ready", 32'(lsu_ready_o), 0);
         end
         if (i >= 6) cmp("burst.drain_order", 32'(waddr_b_o), i - 5);
      end
      idle_inputs();

      // Full queue: push attempted alongside the pop is refused
      for (int i = 0; i < 4; i++) begin
         md_valid_i = 1; md_waddr_i = 5'(20 + i); md_wdata_i = $urandom;
         lsu_valid_i = 1; lsu_waddr_i = 5'(8 + i); lsu_wdata_i = $urandom;
         tick("fill");
      end
      md_valid_i = 0; lsu_waddr_i = 12;
      tick("full_pop_push");
      cmp("full_pop_push.count", 32'(q_count_o), 3);
      cmp("full_pop_push.waddr", 32'(waddr_b_o), 8);
      lsu_valid_i = 0;
      for (int i = 0; i < 4; i++) tick("drain");

      // Scoreboard on x7 and x0
      issue_valid_i = 1; issue_waddr_i = 7; chk_raddr_b_i = 7;
      tick("issue7");
      cmp("x7.stall_set", 32'(stall_o), 1);
      issue_valid_i = 0;
      tick("x7_wait");
      md_valid_i = 1; md_waddr_i = 7; md_wdata_i = 32'h0000_0777;
      tick("x7_write");
      cmp("x7.we", 32'(we_b_o), 1);
      cmp("x7.stall_in_wb", 32'(stall_o), 1);
      md_valid_i = 0;
      tick("x7_done");
      cmp("x7.stall_clear", 32'(stall_o), 0);
      issue_valid_i = 1; issue_waddr_i = 0; chk_raddr_b_i = 0;
      tick("issue0");
      cmp("x0.stall", 32'(stall_o), 0);
      issue_valid_i = 0;
      lsu_valid_i = 1; lsu_waddr_i = 0; lsu_wdata_i = 32'h1234;
      tick("load0_push");
      lsu_valid_i = 0;
      tick("load0_wb");
      cmp("x0.we", 32'(we_b_o), 0);

      // Mult/div and load together into an empty queue
      md_valid_i = 1; md_waddr_i = 20; md_wdata_i = 32'hA5A5_A5A5;
      lsu_valid_i = 1; lsu_waddr_i = 21; lsu_wdata_i = 32'h5A5A_5A5A;
      tick("both_n1");
      cmp("both.md_first", 32'(waddr_b_o), 20);
      idle_inputs();
      tick("both_n2");
      cmp("both.load_second", 32'(waddr_b_o), 21);
      cmp("both.load_data", wdata_b_o, 32'h5A5A_5A5A);

      // Reset mid-operation discards queued loads
      md_valid_i = 1; md_waddr_i = 9; lsu_valid_i = 1; lsu_waddr_i = 10;
      tick("pre_rst1");
      tick("pre_rst2");
      idle_inputs(); rst = 1;
      tick("mid_rst");
      cmp("mid_rst.count", 32'(q_count_o), 0);
      rst = 0;
      tick("post_rst");
      cmp("post_rst.we", 32'(we_b_o), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         md_valid_i    = ($urandom_range(0, 3) == 0);
         md_waddr_i    = 5'($urandom_range(0, 31));
         md_wdata_i    = $urandom;
         lsu_valid_i   = (exp_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
         lsu_waddr_i   = 5'($urandom_range(0, 31));
         lsu_wdata_i   = $urandom;
         issue_valid_i = ($urandom_range(0, 3) == 0);
         issue_waddr_i = 5'($urandom_range(0, 31));
         chk_raddr_a_i = 5'($urandom_range(0, 31));
         chk_raddr_b_i = 5'($urandom_range(0, 31));
         chk_raddr_c_i = 5'($urandom_range(0, 31));
         chk_waddr_i   = 5'($urandom_range(0, 31));
         rst           = ($urandom_range(0, 149) == 0);
         tick("random");
      end
      rst = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
